jtag_user_dr_master: RTL and testbench

// - Host-side JTAG initiator; drives a device's USER data register, the far end of the on-chip BSCANE2 user-scan bridge.
// - One request word is shifted into the USER DR, LSB first. The word captured from TDO is returned as the response.
// - After reset, drives TAP to Test-Logic-Reset, loads IR=USER_IR once, then parks in Run-Test/Idle (RTI).
// - Used in the test harness / probe FPGA that talks to the target chain.

---
 rtl/jtag_pkg.sv | 36 +++
 rtl/jtag_tck_gen.sv | 37 +++
 rtl/jtag_user_dr_master.sv | 170 +++++++++++++++++
 tb/tb_jtag_user_dr_master.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types for the JTAG USER-DR master: TAP step encoding,
// the Test-Logic-Reset length and a small sizing helper.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR,
    GO_RTI,
    IR_SELDR,
    IR_SELIR,
    IR_CAP,
    IR_SHIFT,
    IR_UPD,
    IR_RTI,
    IDLE,
    DR_SEL,
    DR_CAP,
    DR_ENTER,
    DR_SHIFT,
    DR_UPD,
    DR_RTI,
    RESP
  } tap_step_e;

  localparam int TLR_CYCLES = 5;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK prescaler: toggles tck every TCK_DIV clk cycles while run is high.
// Ports: clk, rst, run in; tck, rise_pulse, fall_pulse out.
module jtag_tck_gen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc = (cnt == CW'(TCK_DIV - 1));

  // Pulses mark the clk cycle whose closing edge moves tck.
  assign rise_pulse = run && tc && !tck;
  assign fall_pulse = run && tc && tck;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_user_dr_master.sv
// Host-side JTAG initiator: loads USER_IR once, then exchanges one
// WIDTH-bit word per request through the target's USER data register.
module jtag_user_dr_master
  import jtag_pkg::*;
#(
  parameter int                WIDTH   = 32,
  parameter int                IR_LEN  = 6,
  parameter logic [IR_LEN-1:0] USER_IR = 6'h22,
  parameter int unsigned       TCK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             request_enq__ENA,
  input  logic [WIDTH-1:0] request_enq_v,
  output logic             request_enq__RDY,
  output logic             response_enq__ENA,
  output logic [WIDTH-1:0] response_enq_v,
  input  logic             response_enq__RDY,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  input  logic             TDO
);

  localparam int MAXN = max3(WIDTH, IR_LEN, TLR_CYCLES);
  localparam int BW   = $clog2(MAXN + 1);

  tap_step_e         st;
  logic [BW-1:0]     bcnt;
  logic              last;
  logic              run;
  logic              rise;
  logic              fall;
  logic [WIDTH-1:0]  shreg;
  logic [IR_LEN-1:0] ir_sh;

  jtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck (
    .clk        (CLK),
    .rst        (RST),
    .run        (run),
    .tck        (TCK),
    .rise_pulse (rise),
    .fall_pulse (fall)
  );

  assign last              = (bcnt == BW'(1));
  assign request_enq__RDY  = (st == IDLE);
  assign response_enq__ENA = (st == RESP) && response_enq__RDY;
  assign response_enq_v    = shreg;

  // TMS/TDI for the next step are set on the fall that ends the
  // current step; run starts one cycle after a step sequence begins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st    <= TLR;
      bcnt  <= BW'(TLR_CYCLES);
      TMS   <= 1'b1;
      TDI   <= 1'b0;
      run   <= 1'b0;
      shreg <= '0;
      ir_sh <= '0;
    end else if (st == IDLE) begin
      if (request_enq__ENA) begin
        shreg <= request_enq_v;
        st    <= DR_SEL;
        TMS   <= 1'b1;
      end
    end else if (st == RESP) begin
      if (response_enq__RDY) st <= IDLE;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      if (rise && st == DR_SHIFT)
        shreg <= {TDO, shreg[WIDTH-1:1]};
      if (fall) begin
        unique case (st)
          TLR: begin
            if (last) begin
              st  <= GO_RTI;
              TMS <= 1'b0;
            end else begin
              bcnt <= bcnt - BW'(1);
            end
          end
          GO_RTI: begin
            st  <= IR_SELDR;
            TMS <= 1'b1;
          end
          IR_SELDR: begin
            st  <= IR_SELIR;
            TMS <= 1'b1;
          end
          IR_SELIR: begin
            st   <= IR_CAP;
            TMS  <= 1'b0;
            bcnt <= BW'(2);
          end
          IR_CAP: begin
            if (last) begin
              st    <= IR_SHIFT;
              bcnt  <= BW'(IR_LEN);
              TDI   <= USER_IR[0];
              ir_sh <= USER_IR >> 1;
              TMS   <= (IR_LEN == 1);
            end else begin
              bcnt <= bcnt - BW'(1);
            end
          end
          IR_SHIFT: begin
            if (last) begin
              st  <= IR_UPD;
              TMS <= 1'b1;
              TDI <= 1'b0;
            end else begin
              bcnt  <= bcnt - BW'(1);
              TDI   <= ir_sh[0];
              ir_sh <= ir_sh >> 1;
              TMS   <= (bcnt == BW'(2));
            end
          end
          IR_UPD: begin
            st  <= IR_RTI;
            TMS <= 1'b0;
          end
          IR_RTI: begin
            st  <= IDLE;
            run <= 1'b0;
          end
          DR_SEL: begin
            st  <= DR_CAP;
            TMS <= 1'b0;
          end
          DR_CAP: begin
            st  <= DR_ENTER;
            TMS <= 1'b0;
          end
          DR_ENTER: begin
            st   <= DR_SHIFT;
            bcnt <= BW'(WIDTH);
            TDI  <= shreg[0];
            TMS  <= (WIDTH == 1);
          end
          DR_SHIFT: begin
            if (last) begin
              st  <= DR_UPD;
              TMS <= 1'b1;
              TDI <= 1'b0;
            end else begin
              bcnt <= bcnt - BW'(1);
              TDI  <= shreg[0];
              TMS  <= (bcnt == BW'(2));
            end
          end
          DR_UPD: begin
            st  <= DR_RTI;
            TMS <= 1'b0;
          end
          DR_RTI: begin
            st  <= RESP;
            run <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_user_dr_master.sv
// Bench for jtag_user_dr_master: IEEE 1149.1 TAP model on the main
// instance, plus a WIDTH=8/TCK_DIV=2 instance for latency.
module tb_jtag_user_dr_master;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        req_ena;
  logic [31:0] req_v;
  logic        req_rdy;
  logic        resp_ena;
  logic [31:0] resp_v;
  logic        resp_rdy;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  logic       b_req_ena;
  logic [7:0] b_req_v;
  logic       b_req_rdy;
  logic       b_resp_ena;
  logic [7:0] b_resp_v;
  logic       b_resp_rdy;
  logic       b_tck, b_tms, b_tdi;

  jtag_user_dr_master dut (
    .CLK               (CLK),
    .RST               (RST),
    .request_enq__ENA  (req_ena),
    .request_enq_v     (req_v),
    .request_enq__RDY  (req_rdy),
    .response_enq__ENA (resp_ena),
    .response_enq_v    (resp_v),
    .response_enq__RDY (resp_rdy),
    .TCK               (tck),
    .TMS               (tms),
    .TDI               (tdi),
    .TDO               (tdo)
  );

  jtag_user_dr_master #(
    .WIDTH   (8),
    .IR_LEN  (6),
    .USER_IR (6'h22),
    .TCK_DIV (2)
  ) dut_b (
    .CLK               (CLK),
    .RST               (RST),
    .request_enq__ENA  (b_req_ena),
    .request_enq_v     (b_req_v),
    .request_enq__RDY  (b_req_rdy),
    .response_enq__ENA (b_resp_ena),
    .response_enq_v    (b_resp_v),
    .response_enq__RDY (b_resp_rdy),
    .TCK               (b_tck),
    .TMS               (b_tms),
    .TDI               (b_tdi),
    .TDO               (1'b1)
  );

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;
  int resp_fires = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (resp_ena) resp_fires <= resp_fires + 1;
  end

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SELDR, S_CAPDR, S_SHDR, S_EX1DR,
    S_PAUDR, S_EX2DR, S_UPDDR, S_SELIR, S_CAPIR,
    S_SHIR, S_EX1IR, S_PAUIR, S_EX2IR, S_UPDIR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      S_TLR:   return m ? S_TLR   : S_RTI;
      S_RTI:   return m ? S_SELDR : S_RTI;
      S_SELDR: return m ? S_SELIR : S_CAPDR;
      S_CAPDR: return m ? S_EX1DR : S_SHDR;
      S_SHDR:  return m ? S_EX1DR : S_SHDR;
      S_EX1DR: return m ? S_UPDDR : S_PAUDR;
      S_PAUDR: return m ? S_EX2DR : S_PAUDR;
      S_EX2DR: return m ? S_UPDDR : S_SHDR;
      S_UPDDR: return m ? S_SELDR : S_RTI;
      S_SELIR: return m ? S_TLR   : S_CAPIR;
      S_CAPIR: return m ? S_EX1IR : S_SHIR;
      S_SHIR:  return m ? S_EX1IR : S_SHIR;
      S_EX1IR: return m ? S_UPDIR : S_PAUIR;
      S_PAUIR: return m ? S_EX2IR : S_PAUIR;
      S_EX2IR: return m ? S_UPDIR : S_SHIR;
      S_UPDIR: return m ? S_SELDR : S_RTI;
      default: return S_TLR;
    endcase
  endfunction

  tap_e        tap = S_TLR;
  logic [31:0] dr_sh = '0;
  logic [31:0] cap_val = '0;
  logic [5:0]  ir_sh = '0;
  logic [5:0]  ir_reg = '0;
  int          ir_upd = 0;
  int          ir_bits = 0;
  int          dr_bits = 0;
  int          tck_n = 0;
  bit          tms_hist[$];
  logic [31:0] upd_q[$];
  logic [31:0] exp_upd_q[$];
  logic [31:0] exp_resp_q[$];
  logic [7:0]  b_exp_q[$];

  always @(posedge tck) begin
    case (tap)
      S_CAPDR: begin
        dr_sh   <= cap_val;
        dr_bits <= 0;
      end
      S_SHDR: begin
        dr_sh   <= {tdi, dr_sh[31:1]};
        dr_bits <= dr_bits + 1;
      end
      S_UPDDR: upd_q.push_back(dr_sh);
      S_CAPIR: begin
        ir_sh   <= 6'h01;
        ir_bits <= 0;
      end
      S_SHIR: begin
        ir_sh   <= {tdi, ir_sh[5:1]};
        ir_bits <= ir_bits + 1;
      end
      S_UPDIR: begin
        ir_reg <= ir_sh;
        ir_upd <= ir_upd + 1;
      end
      default: ;
    endcase
    tms_hist.push_back(tms);
    tck_n <= tck_n + 1;
    tap   <= tap_next(tap, tms);
  end

  always @(negedge tck) begin
    if (tap == S_SHDR)      tdo <= dr_sh[0];
    else if (tap == S_SHIR) tdo <= ir_sh[0];
    else                    tdo <= 1'b0;
  end

  // ---------------- drivers ----------------
  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic fire_req(input logic [31:0] v);
    req_v   = v;
    req_ena = 1'b1;
    @(negedge CLK);
    req_ena = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (resp_ena) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (tck !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_tck: got %b want 0", tck);
    end
    n_checks++;
    if (tms !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_tms: got %b want 1", tms);
    end
    n_checks++;
    if (tdi !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_tdi: got %b want 0", tdi);
    end
    n_checks++;
    if (req_rdy !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_req_rdy: got %b want 0", req_rdy);
    end
    n_checks++;
    if (resp_ena !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_resp_ena: got %b want 0", resp_ena);
    end
    n_checks++;
    if (resp_v !== 32'h0) begin
      n_fails++;
      $display("FAIL rst_resp_v: got %h want 0", resp_v);
    end
    tms_hist.delete();
    RST = 1'b0;
  endtask

  task automatic test_init(input int exp_upd);
    bit ok;
    logic [5:0] head;
    wait_rdy(ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL init_timeout: req_rdy never rose");
    end
    head = 6'bx;
    for (int i = 0; i < 6; i++)
      if (tms_hist.size() > i) head[i] = tms_hist[i];
    n_checks++;
    if (head !== 6'b011111) begin
      n_fails++;
      $display("FAIL init_tlr_tms: got %b want 011111", head);
    end
    n_checks++;
    if (tms_hist.size() != 18) begin
      n_fails++;
      $display("FAIL init_tck_count: got %0d want 18",
               tms_hist.size());
    end
    n_checks++;
    if (ir_reg !== 6'h22) begin
      n_fails++;
      $display("FAIL init_ir: got %h want 22", ir_reg);
    end
    n_checks++;
    if (ir_bits != 6) begin
      n_fails++;
      $display("FAIL init_ir_bits: got %0d want 6", ir_bits);
    end
    n_checks++;
    if (ir_upd != exp_upd) begin
      n_fails++;
      $display("FAIL init_ir_upd: got %0d want %0d", ir_upd, exp_upd);
    end
    n_checks++;
    if (tap != S_RTI || tms !== 1'b0 || tck !== 1'b0) begin
      n_fails++;
      $display("FAIL init_park: tap %0d tms %b tck %b want RTI/0/0",
               tap, tms, tck);
    end
  endtask

  task automatic test_transaction;
    bit ok;
    logic [31:0] e;
    wait_rdy(ok);
    cap_val = 32'hDEADBEEF;
    exp_upd_q.push_back(32'hA5A51234);
    exp_resp_q.push_back(32'hDEADBEEF);
    fire_req(32'hA5A51234);
    n_checks++;
    if (req_rdy !== 1'b0) begin
      n_fails++;
      $display("FAIL txn_rdy_drop: got %b want 0", req_rdy);
    end
    wait_resp(ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL txn_timeout: no response");
    end
    e = exp_resp_q.pop_front();
    n_checks++;
    if (resp_v !== e) begin
      n_fails++;
      $display("FAIL txn_resp: got %h want %h", resp_v, e);
    end
    @(negedge CLK);
    e = exp_upd_q.pop_front();
    n_checks++;
    if (upd_q.size() == 0) begin
      n_fails++;
      $display("FAIL txn_update: got none want %h", e);
    end else if (upd_q[0] !== e) begin
      n_fails++;
      $display("FAIL txn_update: got %h want %h", upd_q[0], e);
    end
    upd_q.delete();
    n_checks++;
    if (dr_bits != 32 || req_rdy !== 1'b1) begin
      n_fails++;
      $display("FAIL txn_bits: got %0d rdy %b want 32 rdy 1",
               dr_bits, req_rdy);
    end
  endtask

  task automatic test_latency;
    bit ok;
    int t0;
    int lat;
    logic [7:0] e;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (b_req_rdy) ok = 1'b1;
      else @(negedge CLK);
    end
    b_exp_q.push_back(8'hFF);
    t0 = cyc;
    b_req_v   = 8'h5A;
    b_req_ena = 1'b1;
    @(negedge CLK);
    b_req_ena = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (b_resp_ena) ok = 1'b1;
      else @(negedge CLK);
    end
    lat = cyc - t0;
    n_checks++;
    if (!ok || lat != 54) begin
      n_fails++;
      $display("FAIL lat_cycles: got %0d (seen %b) want 54", lat, ok);
    end
    e = b_exp_q.pop_front();
    n_checks++;
    if (b_resp_v !== e) begin
      n_fails++;
      $display("FAIL lat_resp: got %h want %h", b_resp_v, e);
    end
    @(negedge CLK);
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad;
    int t0;
    logic [31:0] e;
    wait_rdy(ok);
    cap_val = 32'h0F0F5A5A;
    exp_upd_q.push_back(32'h3C3CC3C3);
    exp_resp_q.push_back(32'h0F0F5A5A);
    resp_rdy = 1'b0;
    fire_req(32'h3C3CC3C3);
    repeat (300) @(negedge CLK);
    bad = 0;
    t0 = tck_n;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (tck !== 1'b0 || req_rdy !== 1'b0 || resp_ena !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad != 0 || tck_n != t0) begin
      n_fails++;
      $display("FAIL bp_hold: %0d bad cycles, %0d tck edges want 0/0",
               bad, tck_n - t0);
    end
    resp_rdy = 1'b1;
    #1;
    n_checks++;
    if (resp_ena !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_fire: got %b want 1", resp_ena);
    end
    e = exp_resp_q.pop_front();
    n_checks++;
    if (resp_v !== e) begin
      n_fails++;
      $display("FAIL bp_resp: got %h want %h", resp_v, e);
    end
    @(negedge CLK);
    e = exp_upd_q.pop_front();
    n_checks++;
    if (upd_q.size() != 1 || upd_q[0] !== e) begin
      n_fails++;
      $display("FAIL bp_update: got %0d entries want %h", upd_q.size(), e);
    end
    upd_q.delete();
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit ok2;
    int u0;
    int t0;
    logic [31:0] e;
    wait_rdy(ok);
    u0 = ir_upd;
    t0 = tck_n;
    cap_val = 32'h11112222;
    exp_upd_q.push_back(32'h1);
    exp_resp_q.push_back(32'h11112222);
    fire_req(32'h1);
    wait_resp(ok);
    e = exp_resp_q.pop_front();
    n_checks++;
    if (!ok || resp_v !== e) begin
      n_fails++;
      $display("FAIL b2b_resp1: got %h want %h", resp_v, e);
    end
    @(negedge CLK);
    n_checks++;
    if (req_rdy !== 1'b1 || tms !== 1'b0 || tap != S_RTI) begin
      n_fails++;
      $display("FAIL b2b_gap: rdy %b tms %b tap %0d want 1/0/RTI",
               req_rdy, tms, tap);
    end
    cap_val = 32'h33334444;
    exp_upd_q.push_back(32'h2);
    exp_resp_q.push_back(32'h33334444);
    fire_req(32'h2);
    wait_resp(ok2);
    e = exp_resp_q.pop_front();
    n_checks++;
    if (!ok2 || resp_v !== e) begin
      n_fails++;
      $display("FAIL b2b_resp2: got %h want %h", resp_v, e);
    end
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      e = exp_upd_q.pop_front();
      n_checks++;
      if (upd_q.size() <= k || upd_q[k] !== e) begin
        n_fails++;
        $display("FAIL b2b_update%0d: want %h", k, e);
      end
    end
    upd_q.delete();
    n_checks++;
    if (ir_upd != u0 || tck_n - t0 != 74) begin
      n_fails++;
      $display("FAIL b2b_no_ir: ir_upd +%0d tck %0d want +0 74",
               ir_upd - u0, tck_n - t0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int f0;
    int u0;
    wait_rdy(ok);
    cap_val = 32'h76543210;
    fire_req(32'hCAFEF00D);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (tap == S_SHDR && dr_bits == 10) ok = 1'b1;
      else @(negedge CLK);
    end
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL mid_reach: got bit %0d want 10", dr_bits);
    end
    RST = 1'b1;
    tms_hist.delete();
    f0 = resp_fires;
    u0 = ir_upd;
    @(posedge CLK);
    #1;
    n_checks++;
    if (tck !== 1'b0 || tms !== 1'b1 || tdi !== 1'b0 ||
        req_rdy !== 1'b0 || resp_ena !== 1'b0 || resp_v !== 32'h0) begin
      n_fails++;
      $display("FAIL mid_rst_out: tck %b tms %b tdi %b rdy %b ena %b v %h",
               tck, tms, tdi, req_rdy, resp_ena, resp_v);
    end
    @(negedge CLK);
    RST = 1'b0;
    test_init(u0 + 1);
    upd_q.delete();
    repeat (20) @(negedge CLK);
    n_checks++;
    if (resp_fires != f0) begin
      n_fails++;
      $display("FAIL mid_no_resp: got %0d fires want 0",
               resp_fires - f0);
    end
  endtask

  initial begin
    req_ena    = 1'b0;
    req_v      = '0;
    resp_rdy   = 1'b1;
    b_req_ena  = 1'b0;
    b_req_v    = '0;
    b_resp_rdy = 1'b1;
    RST        = 1'b1;
    test_reset();
    test_init(1);
    test_transaction();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
